// File: rtl/freq_meter_pkg.sv
// Shared definitions for the clock frequency meter.
// FSM state encoding and the default gate window length.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 1 s window at a 50 MHz system clock
    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input into the clk domain and
// emits a one-cycle pulse on each rising edge of the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchronizer, then keep one
    // extra sample of the stable level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed gate window.
// Define FREQ_METER_CONTINUOUS_EN to re-arm the window after every result.
module clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

`ifdef FREQ_METER_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf_int;
    logic             ovf_nxt;
    logic             rise;
    logic             load;
    logic             last_gate;
    logic             cnt_max;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(sig_in),
        .rise   (rise)
    );

    assign last_gate = (state_q == S_GATE) && (gate_cnt == '0);
    assign load      = ((state_q == S_IDLE) && start)
                     || ((state_q == S_DONE) && CONTINUOUS);

    // Saturating edge count including this cycle's pulse; used both for
    // the running count and for the result captured on the last cycle.
    assign cnt_max  = (edge_cnt == '1);
    assign edge_nxt = (rise && !cnt_max) ? edge_cnt + 1'b1 : edge_cnt;
    assign ovf_nxt  = ovf_int | (rise & cnt_max);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_GATE;
            S_GATE: if (gate_cnt == '0) state_d = S_DONE;
            S_DONE: state_d = CONTINUOUS ? S_GATE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Window counters: reload when a window is armed, run during GATE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
        end else if (load) begin
            gate_cnt <= GATE_LOAD;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
        end else if (state_q == S_GATE) begin
            edge_cnt <= edge_nxt;
            ovf_int  <= ovf_nxt;
            if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
        end
    end

    // Capture the result on the last gate cycle so it is valid with done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (last_gate) begin
            count    <= edge_nxt;
            overflow <= ovf_nxt;
        end
    end

    assign busy = (state_q == S_GATE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with a 100-cycle gate window.
// Wide (32-bit) and narrow (4-bit) instances share all stimulus.
module tb_clk_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        busy_w, done_w, ovf_w;
    logic [31:0] count_w;
    logic        busy_n, done_n, ovf_n;
    logic [3:0]  count_n;

`ifdef FREQ_METER_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic wave_en = 1'b0;
    logic wave    = 1'b0;
    logic lvl     = 1'b0;
    int   per     = 4;
    int   ph      = 0;

    always #5 clk = ~clk;

    assign sig_in = wave_en ? wave : lvl;

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (32),
        .SYNC_STAGES(2)
    ) u_wide (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .start   (start),
        .busy    (busy_w),
        .done    (done_w),
        .count   (count_w),
        .overflow(ovf_w)
    );

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (4),
        .SYNC_STAGES(2)
    ) u_narrow (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .start   (start),
        .busy    (busy_n),
        .done    (done_n),
        .count   (count_n),
        .overflow(ovf_n)
    );

    // Square wave: low for per/2 falling edges, then high for per/2,
    // updated just after each falling clk edge.
    always begin
        @(negedge clk);
        #1;
        if (wave_en) begin
            wave = ((ph % per) >= (per / 2));
            ph++;
        end else begin
            wave = 1'b0;
            ph   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy_w"},  busy_w,  0);
        check({tag, " done_w"},  done_w,  0);
        check({tag, " count_w"}, count_w, 0);
        check({tag, " ovf_w"},   ovf_w,   0);
        check({tag, " busy_n"},  busy_n,  0);
        check({tag, " count_n"}, count_n, 0);
        check({tag, " ovf_n"},   ovf_n,   0);
    endtask

    // One measurement from a fresh reset. p=0 means a static level lv.
    // k counts falling edges after the one where start is raised.
    task automatic run(input string tag, input int p, input logic lv,
                       input bit again, input logic [31:0] ew,
                       input logic [31:0] en, input logic eo);
        int d1 = 0;
        int d2 = 0;
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b0;
        wave_en = 1'b0;
        lvl     = lv;
        per     = (p == 0) ? 4 : p;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        start   = 1'b1;
        wave_en = (p != 0);
        for (int k = 1; k <= 210; k++) begin
            @(negedge clk);
            start = again && (k == 50);
            if (k == 1) check({tag, " busy_first"}, busy_w, 1);
            if (k == 100) begin
                check({tag, " busy_last"}, busy_w, 1);
                check({tag, " no_early_done"}, done_w, 0);
            end
            if (done_w) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
                if (d2 == 0 || p == 4 || p == 0) begin
                    check({tag, " count_w"}, count_w, ew);
                    check({tag, " ovf_w"},   ovf_w,   0);
                    check({tag, " count_n"}, count_n, en);
                    check({tag, " ovf_n"},   ovf_n,   eo);
                    check({tag, " done_n"},  done_n,  1);
                end
            end
            if (d1 != 0 && k == d1 + 1) begin
                check({tag, " busy_after"}, busy_w, CONT);
                check({tag, " done_after"}, done_w, 0);
                check({tag, " count_held"}, count_w, ew);
            end
        end
        check({tag, " done_time"}, d1, 101);
        check({tag, " second_done"}, d2, CONT ? 202 : 0);
        wave_en = 1'b0;
    endtask

    initial begin
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_w, 0);

        run("sq4",     4, 1'b0, 1'b0, 25, 15, 1'b1);
        run("lvl0",    0, 1'b0, 1'b0,  0,  0, 1'b0);
        run("lvl1",    0, 1'b1, 1'b0,  0,  0, 1'b0);
        run("sq2",     2, 1'b0, 1'b0, 49, 15, 1'b1);
        run("sq8",     8, 1'b0, 1'b0, 12, 12, 1'b0);
        run("restart", 4, 1'b0, 1'b1, 25, 15, 1'b1);

        // Abort mid-window: everything clears at once and no result follows
        ndone = 0;
        per   = 4;
        @(negedge clk);
        start   = 1'b1;
        wave_en = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 40) begin
                rst = 1'b1;
                #1;
                check_zero("abort");
            end
            if (k == 42) rst = 1'b0;
            if (k > 40 && done_w) ndone++;
        end
        check("abort_no_done", ndone, 0);
        wave_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
